// File: rtl/trap_seq.sv
// Trap/mret sequencer: owns the machine CSR port during trap entry and return,
// one CSR access per cycle, then issues a registered fetch redirect.
module trap_seq #(
  parameter logic [1:0] MSTATUS_MPP_M = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  input  logic        core_csr_we,
  input  logic [11:0] core_csr_addr,
  input  logic [31:0] core_csr_wdata,
  output logic        core_stall,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] A_STAT  = 12'h300;
  localparam logic [11:0] A_VEC   = 12'h305;
  localparam logic [11:0] A_EPC   = 12'h341;
  localparam logic [11:0] A_CAUSE = 12'h342;

  typedef enum logic [2:0] {
    IDLE, RD_STAT, WR_EPC, WR_CAUSE,
    WR_STAT, RD_VEC, RD_EPC, REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [1:0]  type_q;
  logic [31:0] stat_q;
  logic        is_mret;
  logic [31:0] cause;
  logic [31:0] trap_stat;
  logic [31:0] ret_stat;

  assign is_mret = (type_q == 2'b01);

  always_comb begin
    cause = 32'd0;
    unique case (type_q)
      2'b00:   cause = 32'd11;
      2'b10:   cause = 32'd3;
      2'b11:   cause = 32'd2;
      default: cause = 32'd0;
    endcase
  end

  always_comb begin
    trap_stat         = stat_q;
    trap_stat[7]      = stat_q[3];
    trap_stat[3]      = 1'b0;
    trap_stat[12:11]  = MSTATUS_MPP_M;
    ret_stat          = stat_q;
    ret_stat[3]       = stat_q[7];
    ret_stat[7]       = 1'b1;
    ret_stat[12:11]   = MSTATUS_MPP_M;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    core_stall = 1'b1;
    csr_we     = 1'b0;
    csr_addr   = 12'h000;
    csr_wdata  = 32'd0;
    unique case (state_q)
      IDLE: begin
        req_ready  = 1'b1;
        core_stall = 1'b0;
        csr_we     = core_csr_we;
        csr_addr   = core_csr_addr;
        csr_wdata  = core_csr_wdata;
        if (req_valid) state_d = RD_STAT;
      end
      RD_STAT: begin
        csr_addr = A_STAT;
        state_d  = is_mret ? WR_STAT : WR_EPC;
      end
      WR_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = A_EPC;
        csr_wdata = pc_q;
        state_d   = WR_CAUSE;
      end
      WR_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = A_CAUSE;
        csr_wdata = cause;
        state_d   = WR_STAT;
      end
      WR_STAT: begin
        csr_we    = 1'b1;
        csr_addr  = A_STAT;
        csr_wdata = is_mret ? ret_stat : trap_stat;
        state_d   = is_mret ? RD_EPC : RD_VEC;
      end
      RD_VEC: begin
        csr_addr = A_VEC;
        state_d  = REDIR;
      end
      RD_EPC: begin
        csr_addr = A_EPC;
        state_d  = REDIR;
      end
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An abort must not let the in-flight sequencer write land on this edge
    if (!rst_n && state_q != IDLE) begin
      csr_we    = 1'b0;
      csr_addr  = 12'h000;
      csr_wdata = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= 32'd0;
      type_q         <= 2'b00;
      stat_q         <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      state_q        <= state_d;
      redirect_valid <= (state_q == RD_VEC) || (state_q == RD_EPC);
      if (state_q == IDLE && req_valid) begin
        pc_q   <= req_pc;
        type_q <= req_type;
      end
      if (state_q == RD_STAT) stat_q <= csr_rdata;
      if (state_q == RD_VEC || state_q == RD_EPC)
        redirect_pc <= {csr_rdata[31:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq with a small behavioural CSR file
// attached to the sequencer port.
module tb_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_type;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        core_csr_we;
  logic [11:0] core_csr_addr;
  logic [31:0] core_csr_wdata;
  logic        core_stall;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] mstatus = 32'h0000_0008;
  logic [31:0] mtvec   = 32'h8000_0003;
  logic [31:0] mepc    = 32'h0;
  logic [31:0] mcause  = 32'h0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trap_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_type(req_type), .req_pc(req_pc),
    .req_ready(req_ready),
    .core_csr_we(core_csr_we), .core_csr_addr(core_csr_addr),
    .core_csr_wdata(core_csr_wdata), .core_stall(core_stall),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus;
      12'h305: csr_rdata = mtvec;
      12'h341: csr_rdata = mepc;
      12'h342: csr_rdata = mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_addr)
        12'h300: mstatus <= csr_wdata;
        12'h305: mtvec   <= csr_wdata;
        12'h341: mepc    <= csr_wdata;
        12'h342: mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic core_wr(input logic [11:0] a, input logic [31:0] d);
    core_csr_we    = 1'b1;
    core_csr_addr  = a;
    core_csr_wdata = d;
    tick();
    core_csr_we    = 1'b0;
    core_csr_addr  = 12'h0;
    core_csr_wdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_type = 2'b00;
    req_pc = 32'h0;
    core_csr_we = 1'b0;
    core_csr_addr = 12'h0;
    core_csr_wdata = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'h0);
    core_csr_addr = 12'h341;
    core_csr_wdata = 32'h5;
    #1;
    chk("pass_addr", {20'd0, csr_addr}, 32'h341);
    chk("pass_wdata", csr_wdata, 32'h5);
    chk("pass_we", {31'd0, csr_we}, 32'd0);
    core_csr_addr = 12'h0;
    core_csr_wdata = 32'h0;
    tick();

    // ecall
    req_valid = 1'b1; req_type = 2'b00; req_pc = 32'h8000_0100;
    #1;
    chk("ec_t0_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_pc = 32'hFFFF_FFFF;
    chk("ec_t1_addr", {20'd0, csr_addr}, 32'h300);
    chk("ec_t1_we", {31'd0, csr_we}, 32'd0);
    chk("ec_t1_stall", {31'd0, core_stall}, 32'd1);
    chk("ec_t1_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("ec_t2_addr", {20'd0, csr_addr}, 32'h341);
    chk("ec_t2_wdata", csr_wdata, 32'h8000_0100);
    tick();
    chk("ec_t3_addr", {20'd0, csr_addr}, 32'h342);
    chk("ec_t3_wdata", csr_wdata, 32'd11);
    tick();
    chk("ec_t4_wdata", csr_wdata, 32'h0000_1880);
    tick();
    chk("ec_t5_addr", {20'd0, csr_addr}, 32'h305);
    chk("ec_t5_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("ec_t6_rv", {31'd0, redirect_valid}, 32'd1);
    chk("ec_t6_rpc", redirect_pc, 32'h8000_0000);
    chk("ec_t6_we", {31'd0, csr_we}, 32'd0);
    chk("ec_t6_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("ec_t7_rv", {31'd0, redirect_valid}, 32'd0);
    chk("ec_t7_ready", {31'd0, req_ready}, 32'd1);
    chk("ec_mepc", mepc, 32'h8000_0100);
    chk("ec_mcause", mcause, 32'd11);
    chk("ec_mstatus", mstatus, 32'h0000_1880);

    // mret
    core_wr(12'h341, 32'h8000_0104);
    req_valid = 1'b1; req_type = 2'b01; req_pc = 32'h0;
    tick();
    req_valid = 1'b0;
    chk("mr_t1_addr", {20'd0, csr_addr}, 32'h300);
    tick();
    chk("mr_t2_addr", {20'd0, csr_addr}, 32'h300);
    chk("mr_t2_we", {31'd0, csr_we}, 32'd1);
    chk("mr_t2_wdata", csr_wdata, 32'h0000_1888);
    tick();
    chk("mr_t3_addr", {20'd0, csr_addr}, 32'h341);
    chk("mr_t3_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("mr_t4_rv", {31'd0, redirect_valid}, 32'd1);
    chk("mr_t4_rpc", redirect_pc, 32'h8000_0104);
    tick();
    chk("mr_t5_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_t5_rv", {31'd0, redirect_valid}, 32'd0);
    chk("mr_mstatus", mstatus, 32'h0000_1888);
    chk("mr_mcause", mcause, 32'd11);

    // ebreak with a core write in the accept cycle
    req_valid = 1'b1; req_type = 2'b10; req_pc = 32'h20;
    core_csr_we = 1'b1; core_csr_addr = 12'h300; core_csr_wdata = 32'h8;
    #1;
    chk("eb_t0_we", {31'd0, csr_we}, 32'd1);
    tick();
    req_valid = 1'b0;
    core_csr_we = 1'b0; core_csr_addr = 12'h0; core_csr_wdata = 32'h0;
    chk("eb_t1_rdata", csr_rdata, 32'h8);
    repeat (6) tick();
    chk("eb_ready", {31'd0, req_ready}, 32'd1);
    chk("eb_mcause", mcause, 32'd3);
    chk("eb_mepc", mepc, 32'h20);
    chk("eb_mstatus", mstatus, 32'h0000_1880);

    // illegal held high: back-to-back accept
    req_valid = 1'b1; req_type = 2'b11; req_pc = 32'h40;
    tick();
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("il_busy_stall_%0d", i), {31'd0, core_stall}, 32'd1);
      chk($sformatf("il_busy_ready_%0d", i), {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("il_re_ready", {31'd0, req_ready}, 32'd1);
    chk("il_re_stall", {31'd0, core_stall}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("il2_t1_addr", {20'd0, csr_addr}, 32'h300);
    chk("il2_t1_stall", {31'd0, core_stall}, 32'd1);
    repeat (6) tick();
    chk("il_mcause", mcause, 32'd2);
    chk("il_mepc", mepc, 32'h40);
    chk("il_mstatus", mstatus, 32'h0000_1800);
    chk("il_end_ready", {31'd0, req_ready}, 32'd1);

    // reset during WR_CAUSE
    core_wr(12'h300, 32'h8);
    req_valid = 1'b1; req_type = 2'b00; req_pc = 32'h100;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_we_gated", {31'd0, csr_we}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rs_ready", {31'd0, req_ready}, 32'd1);
    chk("rs_stall", {31'd0, core_stall}, 32'd0);
    chk("rs_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rs_rpc", redirect_pc, 32'h0);
    chk("rs_mepc", mepc, 32'h100);
    chk("rs_mcause", mcause, 32'd2);
    chk("rs_mstatus", mstatus, 32'h8);
    repeat (5) begin
      tick();
      chk("rs_no_rv", {31'd0, redirect_valid}, 32'd0);
    end

    // core write attempted while busy
    req_valid = 1'b1; req_type = 2'b00; req_pc = 32'h200;
    tick();
    req_valid = 1'b0;
    core_csr_we = 1'b1; core_csr_addr = 12'h305;
    core_csr_wdata = 32'hDEAD_BEEF;
    #1;
    chk("cb_t1_we", {31'd0, csr_we}, 32'd0);
    tick();
    chk("cb_t2_addr", {20'd0, csr_addr}, 32'h341);
    tick();
    tick();
    tick();
    chk("cb_t5_we", {31'd0, csr_we}, 32'd0);
    chk("cb_t5_rdata", csr_rdata, 32'h8000_0003);
    tick();
    chk("cb_t6_rpc", redirect_pc, 32'h8000_0000);
    core_csr_we = 1'b0; core_csr_addr = 12'h0; core_csr_wdata = 32'h0;
    tick();
    chk("cb_mtvec", mtvec, 32'h8000_0003);
    chk("cb_mepc", mepc, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
